// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, stop bit(s); one-entry holding register for gapless frames.
// Define UART_TX_TWO_STOP_BITS_EN for two stop bits; default build sends one.
module uart_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  send_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  parity_bit_i,
  input  logic                  parity_even_i,
  input  logic [DIV_WIDTH-1:0]  clock_divider_i,
  output logic                  serial_o,
  output logic                  ready_o,
  output logic                  busy_o
);

`ifdef UART_TX_TWO_STOP_BITS_EN
  localparam int STOP_BITS = 2;
`else
  localparam int STOP_BITS = 1;
`endif
  localparam int BIT_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state_q;
  logic                  serial_q, ready_q, busy_q, send_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  par_en_q, par_q;
  logic [DIV_WIDTH-1:0]  div_q, cnt_q;
  logic [BIT_W-1:0]      bit_idx_q;
  logic                  stop_idx_q;
  logic                  hold_full_q, hold_par_en_q, hold_par_even_q;
  logic [DATA_WIDTH-1:0] hold_data_q;

  logic                  accept, bit_end, frame_end, load_hold, load_direct, store_hold;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  ld_par_en, ld_par_even;
  logic [DIV_WIDTH-1:0]  div_eff;

  always_comb begin
    accept      = send_i && !send_q && ready_q;
    bit_end     = (cnt_q == div_q - DIV_WIDTH'(1));
    frame_end   = (state_q == STOP) && bit_end && (stop_idx_q == 1'(STOP_BITS - 1));
    load_hold   = frame_end && hold_full_q;
    // A write landing on the final stop cycle with an empty holding register goes straight to the shifter.
    load_direct = accept && ((state_q == IDLE) || (frame_end && !hold_full_q));
    store_hold  = accept && !load_direct;
    ld_data     = load_hold ? hold_data_q     : data_i;
    ld_par_en   = load_hold ? hold_par_en_q   : parity_bit_i;
    ld_par_even = load_hold ? hold_par_even_q : parity_even_i;
    div_eff     = (clock_divider_i == '0) ? DIV_WIDTH'(1) : clock_divider_i;
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q         <= IDLE;
      serial_q        <= 1'b1;
      ready_q         <= 1'b1;
      busy_q          <= 1'b0;
      send_q          <= 1'b1;
      shift_q         <= '0;
      par_en_q        <= 1'b0;
      par_q           <= 1'b0;
      div_q           <= DIV_WIDTH'(1);
      cnt_q           <= '0;
      bit_idx_q       <= '0;
      stop_idx_q      <= 1'b0;
      hold_full_q     <= 1'b0;
      hold_par_en_q   <= 1'b0;
      hold_par_even_q <= 1'b0;
      hold_data_q     <= '0;
    end else begin
      send_q <= send_i;
      if (store_hold) begin
        hold_full_q     <= 1'b1;
        hold_data_q     <= data_i;
        hold_par_en_q   <= parity_bit_i;
        hold_par_even_q <= parity_even_i;
        ready_q         <= 1'b0;
      end
      if (load_hold) begin
        hold_full_q <= 1'b0;
        ready_q     <= 1'b1;
      end
      if (load_direct || load_hold) begin
        state_q    <= START;
        serial_q   <= 1'b0;
        busy_q     <= 1'b1;
        cnt_q      <= '0;
        bit_idx_q  <= '0;
        stop_idx_q <= 1'b0;
        shift_q    <= ld_data;
        par_en_q   <= ld_par_en;
        par_q      <= ld_par_even ? ^ld_data : ~^ld_data;
        div_q      <= div_eff;
      end else if (state_q != IDLE) begin
        if (!bit_end) begin
          cnt_q <= cnt_q + DIV_WIDTH'(1);
        end else begin
          cnt_q <= '0;
          case (state_q)
            START: begin
              state_q   <= DATA;
              serial_q  <= shift_q[0];
              bit_idx_q <= '0;
            end
            DATA: begin
              if (bit_idx_q == BIT_W'(DATA_WIDTH - 1)) begin
                state_q    <= par_en_q ? PARITY : STOP;
                serial_q   <= par_en_q ? par_q : 1'b1;
                stop_idx_q <= 1'b0;
              end else begin
                shift_q   <= shift_q >> 1;
                serial_q  <= shift_q[1];
                bit_idx_q <= bit_idx_q + BIT_W'(1);
              end
            end
            PARITY: begin
              state_q    <= STOP;
              serial_q   <= 1'b1;
              stop_idx_q <= 1'b0;
            end
            STOP: begin
              if (stop_idx_q == 1'(STOP_BITS - 1)) begin
                state_q  <= IDLE;
                serial_q <= 1'b1;
                busy_q   <= 1'b0;
              end else begin
                stop_idx_q <= 1'b1;
              end
            end
            default: begin
              state_q  <= IDLE;
              serial_q <= 1'b1;
              busy_q   <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign serial_o = serial_q;
  assign ready_o  = ready_q;
  assign busy_o   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: scoreboard of expected frames decoded from serial_o by a line monitor.
module tb_uart_tx;

`ifdef UART_TX_TWO_STOP_BITS_EN
  localparam int SB = 2;
`else
  localparam int SB = 1;
`endif

  logic        clk = 1'b0;
  logic        reset_i, send_i, parity_bit_i, parity_even_i;
  logic [7:0]  data_i;
  logic [15:0] clock_divider_i;
  logic        serial_o, ready_o, busy_o;

  typedef struct {
    logic [7:0] d;
    logic       pen;
    logic       pev;
    int         div;
  } exp_t;

  exp_t sb[$];
  int   busy_lens[$];
  int   frame_starts[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   ready_low = 0;
  bit   mon_en = 1'b1;

  uart_tx #(.DATA_WIDTH(8), .DIV_WIDTH(16)) dut (
    .clock_i(clk), .reset_i(reset_i), .send_i(send_i), .data_i(data_i),
    .parity_bit_i(parity_bit_i), .parity_even_i(parity_even_i),
    .clock_divider_i(clock_divider_i), .serial_o(serial_o),
    .ready_o(ready_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Busy run lengths and ready-low cycles, sampled just after each edge.
  initial begin
    int run = 0;
    forever begin
      @(posedge clk);
      #1;
      if (ready_o === 1'b0) ready_low++;
      if (busy_o === 1'b1) run++;
      else if (run > 0) begin
        busy_lens.push_back(run);
        run = 0;
      end
    end
  end

  task automatic mon_bit(input int d, output logic v, inout bit st);
    v = serial_o;
    for (int i = 1; i < d; i++) begin
      @(posedge clk);
      #2;
      if (serial_o !== v) st = 1'b0;
    end
  endtask

  // Line monitor: every bit must hold its value for exactly div cycles.
  initial begin
    exp_t       e;
    logic       b, stop_ok, exp_par;
    logic [7:0] rx;
    bit         st;
    forever begin
      @(posedge clk);
      #2;
      if (mon_en && reset_i === 1'b1 && serial_o === 1'b0) begin
        if (sb.size() == 0) begin
          check("unexpected_frame", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          frame_starts.push_back(cyc);
          st = 1'b1;
          mon_bit(e.div, b, st);
          check("start_bit", b, 1'b0);
          for (int i = 0; i < 8; i++) begin
            @(posedge clk); #2;
            mon_bit(e.div, b, st);
            rx[i] = b;
          end
          check("data_bits", rx, e.d);
          if (e.pen) begin
            @(posedge clk); #2;
            mon_bit(e.div, b, st);
            exp_par = ($countones(e.d) % 2 == 1) ? e.pev : ~e.pev;
            check("parity_bit", b, exp_par);
          end
          stop_ok = 1'b1;
          for (int s = 0; s < SB; s++) begin
            @(posedge clk); #2;
            mon_bit(e.div, b, st);
            if (b !== 1'b1) stop_ok = 1'b0;
          end
          check("stop_bits", stop_ok, 1'b1);
          check("bit_timing", st, 1'b1);
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic pen, input logic pev,
                      input bit expect_acc, input bit hold);
    exp_t e;
    data_i = d; parity_bit_i = pen; parity_even_i = pev; send_i = 1'b1;
    if (expect_acc) begin
      e.d = d; e.pen = pen; e.pev = pev;
      e.div = (clock_divider_i == 16'd0) ? 1 : int'(clock_divider_i);
      sb.push_back(e);
    end
    tick();
    if (!hold) send_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy_o !== 1'b0 || sb.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check("idle_within_budget", (n < budget), 1'b1);
    tick();
    check("scoreboard_drained", sb.size(), 0);
  endtask

  task automatic check_busy(input string tag, input int exp);
    int v = -1;
    if (busy_lens.size() > 0) v = busy_lens.pop_front();
    check(tag, v, exp);
  endtask

  initial begin
    int rise_cyc;
    reset_i = 1'b0; send_i = 1'b1; data_i = 8'h00;
    parity_bit_i = 1'b0; parity_even_i = 1'b1; clock_divider_i = 16'd2;
    tick(); tick(); tick();
    check("reset_serial", serial_o, 1'b1);
    check("reset_ready", ready_o, 1'b1);
    check("reset_busy", busy_o, 1'b0);

    // send_i high through reset is not an edge
    reset_i = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("held_through_reset_busy", busy_o, 1'b0);
    send_i = 1'b0;
    tick();

    // div=2, no parity, 0x55
    ready_low = 0;
    send(8'h55, 1'b0, 1'b1, 1'b1, 1'b0);
    check("first_start_serial", serial_o, 1'b0);
    wait_idle(200);
    check_busy("busy_len_55", (9 + SB) * 2);
    check("ready_stays_high", ready_low, 0);

    // parity even / odd on 0xAA
    send(8'hAA, 1'b1, 1'b1, 1'b1, 1'b0);
    wait_idle(200);
    check_busy("busy_len_even", (10 + SB) * 2);
    send(8'hAA, 1'b1, 1'b0, 1'b1, 1'b0);
    wait_idle(200);
    check_busy("busy_len_odd", (10 + SB) * 2);

    // back-to-back via holding register, plus a dropped write
    frame_starts.delete();
    send(8'h55, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    send(8'hAA, 1'b0, 1'b1, 1'b1, 1'b0);
    check("ready_low_when_full", ready_o, 1'b0);
    tick();
    send(8'hCC, 1'b0, 1'b1, 1'b0, 1'b0);
    check("ready_low_after_drop", ready_o, 1'b0);
    rise_cyc = -1;
    for (int i = 0; i < 100 && rise_cyc < 0; i++) begin
      tick();
      if (ready_o === 1'b1) rise_cyc = cyc;
    end
    wait_idle(200);
    check_busy("busy_len_b2b", 2 * (9 + SB) * 2);
    check("frames_seen_b2b", frame_starts.size(), 2);
    if (frame_starts.size() == 2) begin
      check("no_idle_gap", frame_starts[1] - frame_starts[0], (9 + SB) * 2);
      check("ready_rise_at_start", rise_cyc, frame_starts[1]);
    end

    // send_i held high after a frame: no retransmit
    send(8'h3C, 1'b0, 1'b1, 1'b1, 1'b1);
    wait_idle(200);
    check_busy("busy_len_3c", (9 + SB) * 2);
    for (int i = 0; i < 12; i++) tick();
    check("no_retransmit", busy_lens.size(), 0);
    send_i = 1'b0;
    tick();

    // reset during data bit 3 of 0x0F
    mon_en = 1'b0;
    send(8'h0F, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) tick();
    check("busy_before_abort", busy_o, 1'b1);
    reset_i = 1'b0;
    tick();
    check("abort_serial", serial_o, 1'b1);
    check("abort_busy", busy_o, 1'b0);
    check("abort_ready", ready_o, 1'b1);
    reset_i = 1'b1;
    tick(); tick();
    busy_lens.delete();
    mon_en = 1'b1;
    send(8'h33, 1'b0, 1'b1, 1'b1, 1'b0);
    wait_idle(200);
    check_busy("busy_len_33", (9 + SB) * 2);

    // div=3, inputs changed mid-frame must not matter
    clock_divider_i = 16'd3;
    send(8'hC5, 1'b0, 1'b1, 1'b1, 1'b0);
    data_i = 8'h00; parity_bit_i = 1'b1; clock_divider_i = 16'd7;
    wait_idle(300);
    check_busy("busy_len_div3", (9 + SB) * 3);

    // divider 0 behaves as 1
    clock_divider_i = 16'd0;
    send(8'h96, 1'b1, 1'b0, 1'b1, 1'b0);
    wait_idle(100);
    check_busy("busy_len_div0", 10 + SB);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
